// File: rtl/pwr_seq_if.sv
// Request/acknowledge and status bundle between the power-sequence arbiter and its domains.
interface pwr_seq_if;
    logic [3:0] off_req;
    logic [3:0] on_req;
    logic [3:0] pwr_ack;
    logic [3:0] pwr_en;
    logic [3:0] iso;
    logic [3:0] save;
    logic [3:0] restore;
    logic [3:0] dom_on;
    logic       busy;
    logic [1:0] cur_dom;
    logic       done;
    logic       err;

    modport slave (
        input  off_req, on_req, pwr_ack,
        output pwr_en, iso, save, restore, dom_on, busy, cur_dom, done, err
    );

    modport master (
        output off_req, on_req, pwr_ack,
        input  pwr_en, iso, save, restore, dom_on, busy, cur_dom, done, err
    );
endinterface

// File: rtl/pwr_seq_arb.sv
// Round-robin power sequencer for four domains: save/isolate/power-down and
// power-up/settle/de-isolate/restore, one domain at a time, with ack timeout.
module pwr_seq_arb #(
    parameter int SAVE_CYC   = 2,
    parameter int SETTLE_CYC = 3,
    parameter int ACK_TO     = 15
) (
    input  logic     clk,
    input  logic     reset,
    pwr_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SAVE, ISO_ON, OFF_WAIT, ON_WAIT, SETTLE, ISO_OFF, RESTORE
    } state_t;

    // Limits compare against a counter cleared on state entry, so each is N-1.
    localparam logic [3:0] SAVE_LIM   = 4'(SAVE_CYC - 1);
    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] ACK_LIM    = 4'(ACK_TO - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] rr;
    logic [1:0] g;
    logic [3:0] pwr_en_q, iso_q, save_q, restore_q, dom_on_q;
    logic       busy_q, done_q, err_q;

    logic [3:0] up_elig, dn_elig, elig;
    logic       found;
    logic [1:0] pick, idx;

    // Scan from the highest offset down so the nearest index after rr wins.
    always_comb begin
        up_elig = bus.on_req & ~dom_on_q;
        dn_elig = bus.off_req & dom_on_q;
        elig    = up_elig | dn_elig;
        found   = 1'b0;
        pick    = rr;
        idx     = rr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rr        <= 2'd0;
            g         <= 2'd0;
            pwr_en_q  <= 4'hF;
            dom_on_q  <= 4'hF;
            iso_q     <= 4'h0;
            save_q    <= 4'h0;
            restore_q <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= cnt + 4'd1;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (found) begin
                        g      <= pick;
                        rr     <= pick + 2'd1;
                        busy_q <= 1'b1;
                        if (up_elig[pick]) begin
                            pwr_en_q[pick] <= 1'b1;
                            state          <= ON_WAIT;
                        end else begin
                            save_q[pick] <= 1'b1;
                            state        <= SAVE;
                        end
                    end
                end
                SAVE: begin
                    if (cnt == SAVE_LIM) begin
                        save_q[g] <= 1'b0;
                        iso_q[g]  <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= ISO_ON;
                    end
                end
                ISO_ON: begin
                    pwr_en_q[g] <= 1'b0;
                    cnt         <= 4'd0;
                    state       <= OFF_WAIT;
                end
                OFF_WAIT: begin
                    // Ack is checked before the timeout so a last-cycle ack still succeeds.
                    if (!bus.pwr_ack[g] || cnt == ACK_LIM) begin
                        dom_on_q[g] <= 1'b0;
                        done_q      <= !bus.pwr_ack[g];
                        err_q       <= bus.pwr_ack[g];
                        busy_q      <= 1'b0;
                        cnt         <= 4'd0;
                        state       <= IDLE;
                    end
                end
                ON_WAIT: begin
                    if (bus.pwr_ack[g]) begin
                        cnt   <= 4'd0;
                        state <= SETTLE;
                    end else if (cnt == ACK_LIM) begin
                        pwr_en_q[g] <= 1'b0;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt         <= 4'd0;
                        state       <= IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LIM) begin
                        iso_q[g] <= 1'b0;
                        cnt      <= 4'd0;
                        state    <= ISO_OFF;
                    end
                end
                ISO_OFF: begin
                    restore_q[g] <= 1'b1;
                    cnt          <= 4'd0;
                    state        <= RESTORE;
                end
                RESTORE: begin
                    if (cnt == SAVE_LIM) begin
                        restore_q[g] <= 1'b0;
                        dom_on_q[g]  <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        cnt          <= 4'd0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pwr_en  = pwr_en_q;
    assign bus.iso     = iso_q;
    assign bus.save    = save_q;
    assign bus.restore = restore_q;
    assign bus.dom_on  = dom_on_q;
    assign bus.busy    = busy_q;
    assign bus.cur_dom = g;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_pwr_seq_arb.sv
// Directed bench for pwr_seq_arb: cycle table for one down/up pair plus
// hand-written sequences for arbitration order, timeouts and reset.
module tb_pwr_seq_arb;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic follow = 1'b0;

    pwr_seq_if ifc ();

    pwr_seq_arb #(.SAVE_CYC(2), .SETTLE_CYC(3), .ACK_TO(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] on_req, off_req, pwr_ack;
        logic [3:0] pwr_en, iso, save, restore, dom_on;
        logic       busy, done, err;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (follow) ifc.pwr_ack = ifc.pwr_en;
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, ifc.pwr_en, ifc.iso, ifc.save, ifc.restore, ifc.dom_on,
                ifc.busy, ifc.done, ifc.err, ifc.cur_dom};
    endfunction

    task automatic chk_reset_vals(input string name);
        chk(name, outs(), {7'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        logic seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            seen = ifc.busy;
        end
        if (!seen) chk({name, "_grant_timeout"}, 32'(ifc.busy), 32'd1);
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            step();
            seen = ifc.done;
        end
        chk({name, "_done"}, 32'(seen), 32'd1);
    endtask

    initial begin
        ifc.on_req  = 4'h0;
        ifc.off_req = 4'h0;
        ifc.pwr_ack = 4'hF;
        reset       = 1'b1;

        //                on    off   ack   pwr_en iso  save rest dom  busy done err
        vecs[0]  = '{4'h0, 4'h1, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 4'hF, 1, 0, 0};
        vecs[1]  = '{4'h0, 4'h1, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 4'hF, 1, 0, 0};
        vecs[2]  = '{4'h0, 4'h1, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 0};
        vecs[3]  = '{4'h0, 4'h1, 4'hF, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 0};
        vecs[4]  = '{4'h0, 4'h1, 4'hF, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 0};
        vecs[5]  = '{4'h0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h0, 4'h0, 4'hE, 0, 1, 0};
        vecs[6]  = '{4'h0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h0, 4'h0, 4'hE, 0, 0, 0};
        vecs[7]  = '{4'h1, 4'h0, 4'hE, 4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[8]  = '{4'h1, 4'h0, 4'hE, 4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[9]  = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[10] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[11] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[12] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hE, 1, 0, 0};
        vecs[13] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'hE, 1, 0, 0};
        vecs[14] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'hE, 1, 0, 0};
        vecs[15] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 0, 1, 0};
        vecs[16] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0};

        step();
        step();
        chk_reset_vals("reset_state");
        reset = 1'b0;

        // Domain 0 down then up, cycle by cycle.
        for (int i = 0; i < 17; i++) begin
            ifc.on_req  = vecs[i].on_req;
            ifc.off_req = vecs[i].off_req;
            ifc.pwr_ack = vecs[i].pwr_ack;
            step();
            chk($sformatf("vec[%0d]", i), outs(),
                {7'd0, vecs[i].pwr_en, vecs[i].iso, vecs[i].save, vecs[i].restore,
                 vecs[i].dom_on, vecs[i].busy, vecs[i].done, vecs[i].err, 2'd0});
        end

        // All four down together: grants 0,1,2,3 with a single idle cycle between.
        begin
            int grants = 0;
            int idle_gap = 0;
            int dones = 0;
            logic prev_busy = 1'b0;
            do_reset();
            follow      = 1'b1;
            ifc.pwr_ack = ifc.pwr_en;
            ifc.off_req = 4'hF;
            for (int n = 0; n < 200 && !(dones == 4 && !ifc.busy); n++) begin
                step();
                if (ifc.busy && !prev_busy) begin
                    chk($sformatf("rr_grant%0d", grants), 32'(ifc.cur_dom), 32'(grants));
                    grants++;
                end
                if (!ifc.busy && grants > 0 && grants < 4) idle_gap++;
                if (ifc.done) dones++;
                prev_busy = ifc.busy;
            end
            chk("rr_grants", 32'(grants), 32'd4);
            chk("rr_idle_gap", 32'(idle_gap), 32'd3);
            chk("rr_final", {20'd0, ifc.dom_on, ifc.pwr_en, ifc.iso}, {20'd0, 4'h0, 4'h0, 4'hF});
            ifc.off_req = 4'h0;
            follow      = 1'b0;
        end

        // Domain 2 up with no ack: timeout after 15 cycles in ON_WAIT.
        ifc.pwr_ack = 4'h0;
        ifc.on_req  = 4'b0100;
        wait_grant("to");
        chk("to_grant", {28'd0, ifc.pwr_en}, 32'h4);
        ifc.on_req = 4'h0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k < 15) chk($sformatf("to_wait%0d", k), {30'd0, ifc.busy, ifc.err}, 32'b10);
        end
        chk("to_err", {30'd0, ifc.busy, ifc.err}, 32'b01);
        chk("to_state", {20'd0, ifc.pwr_en, ifc.iso, ifc.dom_on}, {20'd0, 4'h0, 4'hF, 4'h0});
        step();
        chk("to_err_pulse", 32'(ifc.err), 32'd0);

        // Ack landing on the last allowed cycle counts as success.
        ifc.on_req = 4'b0100;
        wait_grant("edge");
        ifc.on_req = 4'h0;
        for (int k = 1; k <= 14; k++) step();
        ifc.pwr_ack = 4'b0100;
        step();
        chk("edge_ack", {30'd0, ifc.busy, ifc.err}, 32'b10);
        wait_done("edge");
        chk("edge_final", {24'd0, ifc.dom_on, ifc.iso}, {24'd0, 4'b0100, 4'b1011});

        // Both requests on an off domain: up direction wins.
        follow      = 1'b1;
        ifc.pwr_ack = ifc.pwr_en;
        ifc.on_req  = 4'b1000;
        ifc.off_req = 4'b1000;
        wait_grant("both");
        chk("both_grant", {24'd0, ifc.pwr_en, ifc.save}, {24'd0, 4'b1100, 4'h0});
        chk("both_dom", 32'(ifc.cur_dom), 32'd3);
        ifc.on_req  = 4'h0;
        ifc.off_req = 4'h0;
        wait_done("both");
        chk("both_final", {28'd0, ifc.dom_on}, 32'b1100);
        follow = 1'b0;

        // Reset in the middle of a save of domain 1.
        do_reset();
        ifc.pwr_ack = 4'hF;
        ifc.off_req = 4'b0010;
        step();
        chk("mid_save1", {26'd0, ifc.save, ifc.cur_dom}, {26'd0, 4'b0010, 2'd1});
        step();
        chk("mid_save2", {28'd0, ifc.save}, 32'b0010);
        ifc.off_req = 4'h0;
        reset = 1'b1;
        step();
        chk_reset_vals("mid_reset");
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwr_seq_arb.md
PWR_SEQ_ARB -- requirements
Module: pwr_seq_arb

Interface
REQ-001 SHALL have parameter SAVE_CYC, default 2, meaning the number of cycles save or restore is held high for one domain (range 1-15).
REQ-002 SHALL have parameter SETTLE_CYC, default 3, meaning the wait in cycles after power-ack before isolation release (range 1-15).
REQ-003 SHALL have parameter ACK_TO, default 15, meaning the maximum cycles to wait for pwr_ack before timeout (range 1-15).
REQ-004 SHALL have clk, input, 1: the single clock; all flops are posedge.
REQ-005 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have off_req, input, 4: a level request to power down domain i.
REQ-007 SHALL have on_req, input, 4: a level request to power up domain i.
REQ-008 SHALL have pwr_ack, input, 4: the power-switch status for domain i, 1 = rail good.
REQ-009 SHALL have pwr_en, output, 4: the power-switch enable for domain i.
REQ-010 SHALL have iso, output, 4: the isolation enable for domain i.
REQ-011 SHALL have save and restore, output, 4 each: the retention save and restore strobes for domain i.
REQ-012 SHALL have dom_on, output, 4: the committed power state of each domain.
REQ-013 SHALL have busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have cur_dom, output, 2: the index of the granted domain, valid while busy.
REQ-015 SHALL have done, output, 1: a one-cycle pulse when a sequence completes normally.
REQ-016 SHALL have err, output, 1: a one-cycle pulse when a sequence aborts on timeout.

Function
REQ-017 SHALL treat domain i as eligible when (on_req[i] & ~dom_on[i]) or (off_req[i] & dom_on[i]); if both on_req[i] and off_req[i] are high, the on direction SHALL be selected.
REQ-018 SHALL grant one eligible domain in IDLE using round-robin that starts at the index after the last grant; after reset, priority SHALL be 0,1,2,3; with no eligible domain it SHALL stay in IDLE.
REQ-019 SHALL sequence only one domain at a time; the grant index and direction SHALL be latched at grant, and request changes SHALL be ignored until the sequence returns to IDLE.
REQ-020 SHALL implement the following FSM states: IDLE, SAVE, ISO_ON, OFF_WAIT, ON_WAIT, SETTLE, ISO_OFF, RESTORE.
REQ-021 SHALL execute the down sequence as: IDLE -> SAVE (save[g]=1 for exactly SAVE_CYC cycles) -> ISO_ON (iso[g] set, 1 cycle) -> OFF_WAIT (pwr_en[g] cleared, wait until pwr_ack[g]==0) -> IDLE, with dom_on[g] cleared and done pulsed.
REQ-022 SHALL execute the up sequence as: IDLE -> ON_WAIT (pwr_en[g] set, wait until pwr_ack[g]==1) -> SETTLE (SETTLE_CYC cycles) -> ISO_OFF (iso[g] cleared, 1 cycle) -> RESTORE (restore[g]=1 for exactly SAVE_CYC cycles) -> IDLE, with dom_on[g] set and done pulsed.
REQ-023 SHALL use one 4-bit counter, cleared on every state entry, for SAVE, SETTLE, RESTORE and the ack timeout; the counter SHALL never wrap because every limit is at most 15.
REQ-024 SHALL abort ON_WAIT when ACK_TO cycles elapse without pwr_ack[g]==1: pwr_en[g] cleared, iso[g] kept at 1, dom_on[g] kept at 0, err pulsed, return to IDLE, no done.
REQ-025 SHALL handle an OFF_WAIT timeout as follows: pwr_en[g] stays 0, iso[g] stays 1, dom_on[g] cleared, err pulsed, return to IDLE, no done.
REQ-026 SHALL check for timeout only after the ack condition: an ack arriving in the same cycle that the count reaches ACK_TO SHALL count as success.
REQ-027 SHALL keep iso[i]=1 for any domain with dom_on[i]=0; save and restore SHALL never both be high, and at most one bit of each SHALL be set.
REQ-028 SHALL update all outputs as registered values; done and err SHALL assert in the cycle the FSM re-enters IDLE, and a new grant SHALL be possible the following cycle.

Reset
REQ-029 SHALL, on reset at any clock edge and including mid-sequence, set the FSM to IDLE, the counter to 0, the RR pointer so domain 0 is first, pwr_en=4'hF, dom_on=4'hF, iso=0, save=0, restore=0, busy=0, done=0, err=0 and cur_dom=0.

Verification
REQ-030 SHALL verify: off_req=4'b0001, pwr_ack[0] drops 2 cycles after pwr_en[0] falls -> save[0] high 2 cycles, iso[0]=1, pwr_en[0]=0, dom_on=4'hE, one done.
REQ-031 SHALL verify: with domain 0 off, on_req=4'b0001, pwr_ack[0] rises 1 cycle later -> 3 settle cycles, iso[0]=0, restore[0] high 2 cycles, dom_on=4'hF, done.
REQ-032 SHALL verify: off_req=4'hF held -> grants in order 0,1,2,3, one at a time, busy continuous except 1 IDLE cycle between grants.
REQ-033 SHALL verify: on_req[2] with pwr_ack[2] held 0 -> err after 15 cycles, pwr_en[2]=0, iso[2]=1, dom_on[2]=0.
REQ-034 SHALL verify: reset asserted during SAVE of domain 1 -> next cycle all outputs at reset values, dom_on=4'hF.
REQ-035 SHALL verify: on_req[3] and off_req[3] both high with domain 3 off -> up sequence runs.
